seq_ram_loader: RTL and testbench
=================================

// Module: seq_ram_loader
// PURPOSE
//  Symbol-insertion front end of the RAM signal-management path. Accepts an ASCII nucleotide stream
//  over a valid/ready handshake, encodes each symbol to 2 bits and packs 4 symbols per 8-bit RAM word.
//  Drives the RAM write port and produces en_ins, one pulse per inserted symbol, for the downstream
//  4-insertion counter. Also tracks sequence length and end-of-load for the NW scoring controller.
// PARAMETERS
//  DEPTH  16             number of 8-bit words in the target sequence RAM (power of 2, >=2)
//  AW     $clog2(DEPTH)  RAM address width
//  LW     AW+3           width of seq_len; holds 0..4*DEPTH
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous, active-low reset (sampled on posedge clk, low = reset)
//  start        in   1   1-cycle pulse: clear state and begin a new load
//  sym_valid    in   1   sym_data holds a symbol
//  sym_data     in   8   ASCII symbol: A/C/G/T, upper or lower case
//  sym_last     in   1   qualifies final symbol of the sequence
//  sym_ready    out  1   loader can accept a symbol this cycle
//  en_ins       out  1   combinational: a valid symbol is accepted this cycle
//  ram_we       out  1   registered RAM write strobe, 1-cycle pulse
//  ram_addr     out  AW  RAM write address
//  ram_wdata    out  8   packed word; symbol k of word at bits [2k+1:2k]
//  seq_len      out  LW  count of valid symbols accepted in current load
//  done         out  1   level: load finished, held until start or reset
//  err_bad_sym  out  1   sticky: non-ACGT symbol seen in current load
//  err_full     out  1   sticky: RAM filled before sym_last
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE; every output 0; pack reg, slot idx, addr and seq_len 0.
//  - Encoding: A/a=00, C/c=01, G/g=10, T/t=11. Other codes: accepted, not stored, not counted,
//    en_ins stays 0, err_bad_sym set. A bad symbol with sym_last still ends the load.
//  - Handshake: accept = sym_valid & sym_ready. sym_ready=1 only in LOAD.
//    sym_data/sym_last are sampled only on accept.
//  - FSM IDLE -> LOAD on start.
//    LOAD: each valid accept writes code into slot idx (0..3), idx++, seq_len++.
//    Slot-3 accept: next cycle ram_we=1, ram_wdata=full word, ram_addr=current addr;
//    then addr++ and idx wraps to 0. Latency is 1 cycle from the 4th accept to ram_we.
//  - sym_last accepted with idx!=3 after the store (partial word, or no new data after a bad symbol):
//    LOAD -> FLUSH. FLUSH writes the partial word for 1 cycle with unused slots 0, unless no
//    symbols are pending, in which case nothing is written. FLUSH -> DONE.
//  - sym_last accepted on slot 3: the normal write occurs, then LOAD -> DONE with no FLUSH.
//  - Full: slot-3 write at addr=DEPTH-1 without sym_last -> DONE with err_full=1.
//    Address never wraps and no further writes occur.
//  - DONE: sym_ready=0 and done=1; ram_addr holds the last written address. start -> LOAD with
//    all counters, errors and done cleared.
//  - start while in LOAD or FLUSH aborts: pending partial word is discarded (no write), state
//    cleared, -> LOAD next cycle. start takes priority over a same-cycle accept; that symbol is dropped.
//  - Reset mid-operation aborts the same way, returning to IDLE; no write is issued in that cycle.
//  - en_ins = accept & valid_code & (state==LOAD) & ~start. Four en_ins pulses are always
//    followed by exactly one ram_we.
//  - seq_len saturates at 4*DEPTH.
// STRUCTURE
//  - Shared header nw_defs.vh: nucleotide 2-bit codes (NT_A..NT_T), ASCII constants, FSM state
//    encodings (IDLE/LOAD/FLUSH/DONE), SYM_PER_WORD=4.
//  - Sub-module nt_encoder: combinational 8-bit ASCII -> {valid, code[1:0]}.
//  - Top: FSM, 2-bit slot idx, 8-bit pack reg, AW-bit addr counter, LW-bit length counter,
//    error flags.
// TESTING
//  1. start, send "ACGT" with last on T -> one ram_we at addr 0, wdata=8'hE4, seq_len=4, done=1, no FLUSH write.
//  2. start, send "GATTACA" with last on 2nd A -> writes 8'hF2@0, then FLUSH 8'h04@1; seq_len=7.
//  3. DEPTH=2, send 9 symbols of 'T' with no last -> writes 8'hFF@0 and @1, err_full=1,
//     9th symbol refused (sym_ready=0), seq_len=8.
//  4. Send "AxC" with last on C -> err_bad_sym=1, en_ins pulses=2, FLUSH wdata=8'h04, seq_len=2.
//  5. Send "AC", then start pulse concurrent with valid 'G' -> no write, seq_len=0, 'G' dropped,
//     state LOAD; rst=0 mid-load -> all outputs 0.
//  6. Randomised sym_valid gaps with back-to-back accepts -> ram_we count == floor(seq_len/4)+partial,
//     en_ins count == seq_len.

Source files
------------

// File: rtl/seq_ram_loader_pkg.sv
// Shared definitions for the sequence RAM loader: nucleotide codes, ASCII symbols,
// FSM states and the slot-packing helper.
package seq_ram_loader_pkg;

   localparam int SYM_PER_WORD = 4;

   localparam logic [1:0] NT_A = 2'b00;
   localparam logic [1:0] NT_C = 2'b01;
   localparam logic [1:0] NT_G = 2'b10;
   localparam logic [1:0] NT_T = 2'b11;

   localparam logic [7:0] ASCII_A_UC = 8'h41;
   localparam logic [7:0] ASCII_C_UC = 8'h43;
   localparam logic [7:0] ASCII_G_UC = 8'h47;
   localparam logic [7:0] ASCII_T_UC = 8'h54;
   localparam logic [7:0] ASCII_A_LC = 8'h61;
   localparam logic [7:0] ASCII_C_LC = 8'h63;
   localparam logic [7:0] ASCII_G_LC = 8'h67;
   localparam logic [7:0] ASCII_T_LC = 8'h74;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Returns word with the 2-bit code inserted at the given slot (slot k -> bits [2k+1:2k]).
   function automatic logic [7:0] place_code(input logic [7:0] word,
                                             input logic [1:0] slot,
                                             input logic [1:0] code);
      logic [7:0] w;
      w = word;
      case (slot)
         2'd0:    w[1:0] = code;
         2'd1:    w[3:2] = code;
         2'd2:    w[5:4] = code;
         2'd3:    w[7:6] = code;
         default: w = word;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/seq_ram_loader_nt_encoder.sv
// Combinational ASCII nucleotide encoder: A/C/G/T in either case map to a 2-bit code,
// anything else is flagged as not a nucleotide.
module nt_encoder
   import seq_ram_loader_pkg::*;
(
   input  logic [7:0] ascii,
   output logic       sym_ok,
   output logic [1:0] code
);

   // Case-insensitive symbol lookup.
   always_comb begin
      sym_ok = 1'b1;
      code   = NT_A;
      case (ascii)
         ASCII_A_UC, ASCII_A_LC: code = NT_A;
         ASCII_C_UC, ASCII_C_LC: code = NT_C;
         ASCII_G_UC, ASCII_G_LC: code = NT_G;
         ASCII_T_UC, ASCII_T_LC: code = NT_T;
         default: begin
            sym_ok = 1'b0;
            code   = NT_A;
         end
      endcase
   end

endmodule

// File: rtl/seq_ram_loader.sv
// Symbol-insertion front end: accepts an ASCII nucleotide stream, packs four 2-bit codes
// per RAM word, drives the RAM write port and reports length, completion and errors.
module seq_ram_loader
   import seq_ram_loader_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int LW    = AW + 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          sym_valid,
   input  logic [7:0]    sym_data,
   input  logic          sym_last,
   output logic          sym_ready,
   output logic          en_ins,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   output logic [LW-1:0] seq_len,
   output logic          done,
   output logic          err_bad_sym,
   output logic          err_full
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [LW-1:0] MAX_LEN   = LW'(SYM_PER_WORD * DEPTH);

   state_t        state_r;
   logic [1:0]    idx_r;
   logic [7:0]    pack_r;
   logic [AW-1:0] addr_r;

   logic          code_ok_s;
   logic [1:0]    code_s;
   logic          accept_s;
   logic [7:0]    word_s;

   nt_encoder u_enc (
      .ascii  (sym_data),
      .sym_ok (code_ok_s),
      .code   (code_s)
   );

   // Ready is forced low while reset is held so nothing is handed over in that cycle.
   assign sym_ready = rst & (state_r == ST_LOAD);
   assign accept_s  = sym_valid & sym_ready & ~start;
   assign en_ins    = accept_s & code_ok_s;
   assign word_s    = place_code(pack_r, idx_r, code_s);

   // Load FSM with packing, address/length counters, error flags and registered RAM port.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= 2'd0;
         pack_r      <= 8'h00;
         addr_r      <= '0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= 8'h00;
         seq_len     <= '0;
         done        <= 1'b0;
         err_bad_sym <= 1'b0;
         err_full    <= 1'b0;
      end else if (start) begin
         // A start in any state discards pending data and begins a fresh load.
         state_r     <= ST_LOAD;
         idx_r       <= 2'd0;
         pack_r      <= 8'h00;
         addr_r      <= '0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= 8'h00;
         seq_len     <= '0;
         done        <= 1'b0;
         err_bad_sym <= 1'b0;
         err_full    <= 1'b0;
      end else begin
         ram_we <= 1'b0;
         case (state_r)
            ST_LOAD: begin
               if (accept_s) begin
                  if (!code_ok_s) begin
                     err_bad_sym <= 1'b1;
                     if (sym_last) begin
                        state_r <= ST_FLUSH;
                     end
                  end else begin
                     if (seq_len != MAX_LEN) begin
                        seq_len <= seq_len + LW'(1);
                     end
                     if (idx_r == 2'd3) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= word_s;
                        ram_addr  <= addr_r;
                        pack_r    <= 8'h00;
                        idx_r     <= 2'd0;
                        if (sym_last) begin
                           state_r <= ST_DONE;
                           done    <= 1'b1;
                        end else if (addr_r == LAST_ADDR) begin
                           // Last word written without an end marker: stop, never wrap.
                           state_r  <= ST_DONE;
                           done     <= 1'b1;
                           err_full <= 1'b1;
                        end else begin
                           addr_r <= addr_r + AW'(1);
                        end
                     end else begin
                        pack_r <= word_s;
                        idx_r  <= idx_r + 2'd1;
                        if (sym_last) begin
                           state_r <= ST_FLUSH;
                        end
                     end
                  end
               end
            end
            ST_FLUSH: begin
               // Only write when there are symbols waiting in the pack register.
               if (idx_r != 2'd0) begin
                  ram_we    <= 1'b1;
                  ram_wdata <= pack_r;
                  ram_addr  <= addr_r;
               end
               pack_r  <= 8'h00;
               idx_r   <= 2'd0;
               state_r <= ST_DONE;
               done    <= 1'b1;
            end
            ST_IDLE, ST_DONE: begin
               state_r <= state_r;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_ram_loader.sv
// Randomised self-checking bench: two loaders (DEPTH 16 and DEPTH 2) share one symbol stream
// and each is compared against a transaction-level model of the load rules.
module tb_seq_ram_loader;

   localparam int DEPTH_LG = 16;
   localparam int DEPTH_SM = 2;
   localparam int AW_LG = $clog2(DEPTH_LG);
   localparam int LW_LG = AW_LG + 3;
   localparam int AW_SM = $clog2(DEPTH_SM);
   localparam int LW_SM = AW_SM + 3;

   typedef struct packed {
      int id;
      int cyc;
      int addr;
      int data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic sym_valid = 1'b0;
   logic sym_last = 1'b0;
   logic [7:0] sym_data = 8'h00;

   logic ready_lg, en_lg, we_lg, done_lg, bad_lg, full_lg;
   logic [AW_LG-1:0] addr_lg;
   logic [7:0] wdata_lg;
   logic [LW_LG-1:0] len_lg;
   logic ready_sm, en_sm, we_sm, done_sm, bad_sm, full_sm;
   logic [AW_SM-1:0] addr_sm;
   logic [7:0] wdata_sm;
   logic [LW_SM-1:0] len_sm;

   int cyc = 0;
   int ens_lg = 0;
   int ens_sm = 0;
   int n_vec = 0;
   int n_bad = 0;
   wr_t got_q[$];
   byte unsigned sq[$];
   bit lq[$];
   int pres[$];

   seq_ram_loader #(.DEPTH(DEPTH_LG)) dut_lg (
      .clk(clk), .rst(rst), .start(start), .sym_valid(sym_valid), .sym_data(sym_data),
      .sym_last(sym_last), .sym_ready(ready_lg), .en_ins(en_lg), .ram_we(we_lg),
      .ram_addr(addr_lg), .ram_wdata(wdata_lg), .seq_len(len_lg), .done(done_lg),
      .err_bad_sym(bad_lg), .err_full(full_lg)
   );

   seq_ram_loader #(.DEPTH(DEPTH_SM)) dut_sm (
      .clk(clk), .rst(rst), .start(start), .sym_valid(sym_valid), .sym_data(sym_data),
      .sym_last(sym_last), .sym_ready(ready_sm), .en_ins(en_sm), .ram_we(we_sm),
      .ram_addr(addr_sm), .ram_wdata(wdata_sm), .seq_len(len_sm), .done(done_sm),
      .err_bad_sym(bad_sm), .err_full(full_sm)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record RAM writes and insertion pulses mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         if (we_lg) got_q.push_back('{0, cyc, int'(addr_lg), int'(wdata_lg)});
         if (we_sm) got_q.push_back('{1, cyc, int'(addr_sm), int'(wdata_sm)});
         if (en_lg) ens_lg <= ens_lg + 1;
         if (en_sm) ens_sm <= ens_sm + 1;
      end
   end

   task automatic chk_eq(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_code(input byte unsigned c);
      string up;
      string lo;
      up = "ACGT";
      lo = "acgt";
      for (int k = 0; k < 4; k++) begin
         if (c == up[k] || c == lo[k]) return k;
      end
      return -1;
   endfunction

   task automatic set_seq(input string s, input int last_pos);
      sq.delete();
      lq.delete();
      for (int i = 0; i < s.len(); i++) begin
         sq.push_back(s[i]);
         lq.push_back(i == last_pos);
      end
   endtask

   task automatic check_quiet(input string tag);
      chk_eq({tag, "_ready_lg"}, ready_lg, 0);
      chk_eq({tag, "_en_lg"}, en_lg, 0);
      chk_eq({tag, "_we_lg"}, we_lg, 0);
      chk_eq({tag, "_addr_lg"}, addr_lg, 0);
      chk_eq({tag, "_wdata_lg"}, wdata_lg, 0);
      chk_eq({tag, "_len_lg"}, len_lg, 0);
      chk_eq({tag, "_done_lg"}, done_lg, 0);
      chk_eq({tag, "_bad_lg"}, bad_lg, 0);
      chk_eq({tag, "_full_lg"}, full_lg, 0);
      chk_eq({tag, "_ready_sm"}, ready_sm, 0);
      chk_eq({tag, "_en_sm"}, en_sm, 0);
      chk_eq({tag, "_we_sm"}, we_sm, 0);
      chk_eq({tag, "_len_sm"}, len_sm, 0);
      chk_eq({tag, "_done_sm"}, done_sm, 0);
   endtask

   // Model: walk the offered symbols, pack valid codes four to a word, and decide
   // where the load ends (end marker or RAM full); compare against what was observed.
   task automatic check_load(input int id, input int depth, input int base_w,
                             input int got_en, input int got_len, input int got_done,
                             input int got_bad, input int got_full, input int got_ready,
                             input int got_addr);
      int n;
      int addr;
      int word;
      bit ended;
      bit bad;
      bit full;
      wr_t exp_q[$];
      wr_t obs_q[$];
      string p;
      n = 0; addr = 0; word = 0; ended = 0; bad = 0; full = 0;
      p = (id == 0) ? "lg" : "sm";
      for (int i = 0; i < sq.size() && !ended; i++) begin
         int c;
         c = ref_code(sq[i]);
         if (c < 0) begin
            bad = 1;
         end else begin
            word += c << (2 * (n % 4));
            n++;
            if (n % 4 == 0) begin
               exp_q.push_back('{id, pres[i] + 1, addr, word});
               word = 0;
               if (!lq[i] && addr == depth - 1) begin
                  full = 1;
                  ended = 1;
               end else if (!lq[i]) begin
                  addr++;
               end
            end
         end
         if (lq[i] && !ended) begin
            ended = 1;
            if (n % 4 != 0) exp_q.push_back('{id, pres[i] + 2, addr, word});
         end
      end
      foreach (got_q[j]) begin
         if (j >= base_w && got_q[j].id == id) obs_q.push_back(got_q[j]);
      end
      chk_eq({p, "_nwrites"}, obs_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
         chk_eq({p, "_wcyc"}, obs_q[j].cyc, exp_q[j].cyc);
         chk_eq({p, "_waddr"}, obs_q[j].addr, exp_q[j].addr);
         chk_eq({p, "_wdata"}, obs_q[j].data, exp_q[j].data);
      end
      chk_eq({p, "_en_count"}, got_en, n);
      chk_eq({p, "_seq_len"}, got_len, n);
      chk_eq({p, "_done"}, got_done, ended);
      chk_eq({p, "_bad_sym"}, got_bad, bad);
      chk_eq({p, "_full"}, got_full, full);
      chk_eq({p, "_ready"}, got_ready, !ended);
      chk_eq({p, "_ram_addr"}, got_addr, (exp_q.size() > 0) ? exp_q[exp_q.size() - 1].addr : 0);
   endtask

   task automatic do_load(input bit gaps);
      int bw;
      int be_lg;
      int be_sm;
      pres.delete();
      @(posedge clk); #1;
      bw = got_q.size();
      be_lg = ens_lg;
      be_sm = ens_sm;
      start = 1'b1;
      sym_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      foreach (sq[i]) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               sym_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         sym_valid = 1'b1;
         sym_data = sq[i];
         sym_last = lq[i];
         pres.push_back(cyc);
         @(posedge clk); #1;
      end
      sym_valid = 1'b0;
      sym_last = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check_load(0, DEPTH_LG, bw, ens_lg - be_lg, int'(len_lg), int'(done_lg), int'(bad_lg),
                 int'(full_lg), int'(ready_lg), int'(addr_lg));
      check_load(1, DEPTH_SM, bw, ens_sm - be_sm, int'(len_sm), int'(done_sm), int'(bad_sm),
                 int'(full_sm), int'(ready_sm), int'(addr_sm));
   endtask

   initial begin
      int bw;
      int be;
      string alpha;
      alpha = "ACGTacgt";

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      rst = 1'b1;

      set_seq("ACGT", 3);      do_load(1'b0);
      set_seq("GATTACA", 6);   do_load(1'b0);
      set_seq("TTTTTTTTT", -1); do_load(1'b0);
      set_seq("AxC", 2);       do_load(1'b0);

      // Abort: start arrives together with a valid 'G', which must be dropped.
      set_seq("AC", -1);       do_load(1'b0);
      bw = got_q.size();
      be = ens_lg;
      start = 1'b1;
      sym_valid = 1'b1;
      sym_data = 8'h47;
      sym_last = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      sym_valid = 1'b0;
      @(posedge clk); #1;
      chk_eq("abort_len", len_lg, 0);
      chk_eq("abort_ready", ready_lg, 1);
      chk_eq("abort_en", ens_lg - be, 0);
      chk_eq("abort_writes", got_q.size() - bw, 0);

      // Reset in the middle of a load with a symbol on offer.
      sym_valid = 1'b1;
      sym_data = 8'h41;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_quiet("midreset");
      sym_valid = 1'b0;
      rst = 1'b1;

      for (int t = 0; t < 40; t++) begin
         int len;
         len = $urandom_range(1, 70);
         sq.delete();
         lq.delete();
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 15) == 0) sq.push_back(8'($urandom_range(0, 255)));
            else sq.push_back(alpha[$urandom_range(0, 7)]);
            if (i == len - 1) lq.push_back($urandom_range(0, 7) != 0);
            else lq.push_back($urandom_range(0, 63) == 0);
         end
         do_load(1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
